bcd_addsub_seq: RTL and testbench

Digit-serial signed-magnitude BCD add/subtract unit for the calculator datapath. It takes two DIGITS-wide packed-BCD operands, each with its own sign bit. It produces a sign-magnitude BCD result with overflow and invalid-digit error reporting. A start/busy/done handshake lets the calculator controller launch one operation and wait a fixed number of cycles for the result.

---
 rtl/bcd_addsub_seq_pkg.sv | 18 +
 rtl/bcd_digit_addsub.sv | 33 +++
 rtl/bcd_addsub_seq.sv | 150 +++++++++++++++
 tb/tb_bcd_addsub_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_addsub_seq_pkg.sv
// Shared types and constants for the digit-serial
// signed-magnitude BCD add/subtract unit.
package bcd_addsub_seq_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    CHECK
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_BCD  = 2'b10;

endpackage

// File: rtl/bcd_digit_addsub.sv
// One BCD digit of add (decimal carry) or
// subtract (decimal borrow), purely combinational.
module bcd_digit_addsub
  import bcd_addsub_seq_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic [BCD_W-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic [BCD_W-1:0] d,
  output logic             cout
);

  logic [BCD_W:0] t;

  always_comb begin
    t    = '0;
    d    = '0;
    cout = 1'b0;
    if (sub) begin
      t    = {1'b0, x} - {1'b0, y} - {4'b0, cin};
      cout = t[BCD_W];
      d    = cout ? t[BCD_W-1:0] + 4'd10
                  : t[BCD_W-1:0];
    end else begin
      t    = {1'b0, x} + {1'b0, y} + {4'b0, cin};
      cout = t > 5'd9;
      d    = cout ? t[BCD_W-1:0] - 4'd10
                  : t[BCD_W-1:0];
    end
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial signed-magnitude BCD add/subtract
// with start/busy/done handshake and error codes.
module bcd_addsub_seq
  import bcd_addsub_seq_pkg::*;
#(
  parameter int DIGITS     = 6,
  parameter bit SIGN_DIGIT = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_op,
  input  logic                    i_a_sign,
  input  logic [BCD_W*DIGITS-1:0] i_a,
  input  logic                    i_b_sign,
  input  logic [BCD_W*DIGITS-1:0] i_b,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [BCD_W*DIGITS-1:0] o_res,
  output logic                    o_sign,
  output logic                    o_err,
  output logic [1:0]              o_err_code
);

  localparam int W  = BCD_W * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t        state;
  logic          op_q, as_q, bs_q;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  x_sr, y_sr, acc;
  logic          cy, eff_sub, swap, inval;
  logic [CW-1:0] cnt;

  logic          bad;
  logic [3:0]    dig;
  logic          dig_c;
  logic          zero, neg, ovf;

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_q[i*BCD_W +: BCD_W] > 4'd9) bad = 1'b1;
      if (b_q[i*BCD_W +: BCD_W] > 4'd9) bad = 1'b1;
    end
  end

  bcd_digit_addsub u_dig (
    .x    (x_sr[BCD_W-1:0]),
    .y    (y_sr[BCD_W-1:0]),
    .cin  (cy),
    .sub  (eff_sub),
    .d    (dig),
    .cout (dig_c)
  );

  // after CALC, cy holds the carry out of the top digit
  always_comb begin
    zero = (acc == '0);
    neg  = ~zero & (swap ? (bs_q ^ op_q) : as_q);
    ovf  = (~eff_sub & cy) |
           (SIGN_DIGIT && neg &&
            (acc[W-1 -: BCD_W] != '0));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      op_q       <= 1'b0;
      as_q       <= 1'b0;
      bs_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      x_sr       <= '0;
      y_sr       <= '0;
      acc        <= '0;
      cy         <= 1'b0;
      eff_sub    <= 1'b0;
      swap       <= 1'b0;
      inval      <= 1'b0;
      cnt        <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_res      <= '0;
      o_sign     <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= ERR_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          o_done <= 1'b0;
          o_busy <= i_start;
          if (i_start) begin
            op_q  <= i_op;
            as_q  <= i_a_sign;
            bs_q  <= i_b_sign;
            a_q   <= i_a;
            b_q   <= i_b;
            state <= LOAD;
          end
        end
        LOAD: begin
          inval   <= bad;
          eff_sub <= op_q ^ as_q ^ bs_q;
          swap    <= (op_q ^ as_q ^ bs_q) & (b_q > a_q);
          if ((op_q ^ as_q ^ bs_q) & (b_q > a_q)) begin
            x_sr <= b_q;
            y_sr <= a_q;
          end else begin
            x_sr <= a_q;
            y_sr <= b_q;
          end
          cy    <= 1'b0;
          cnt   <= '0;
          state <= CALC;
        end
        CALC: begin
          acc  <= {dig, acc[W-1:BCD_W]};
          x_sr <= x_sr >> BCD_W;
          y_sr <= y_sr >> BCD_W;
          cy   <= dig_c;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          o_done <= 1'b1;
          state  <= IDLE;
          if (inval || ovf) begin
            o_res      <= '0;
            o_sign     <= 1'b0;
            o_err      <= 1'b1;
            o_err_code <= inval ? ERR_BCD : ERR_OVF;
          end else begin
            o_res      <= acc;
            o_sign     <= neg;
            o_err      <= 1'b0;
            o_err_code <= ERR_NONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Bench for bcd_addsub_seq: directed cases plus random
// operands against an integer-arithmetic reference.
module tb_bcd_addsub_seq;

  localparam int D = 6;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, op, a_s, b_s;
  logic [W-1:0] a, b;

  logic         busy1, done1, sign1, err1;
  logic [W-1:0] res1;
  logic [1:0]   code1;
  logic         busy0, done0, sign0, err0;
  logic [W-1:0] res0;
  logic [1:0]   code0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bcd_addsub_seq #(.DIGITS(D), .SIGN_DIGIT(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_op(op), .i_a_sign(a_s), .i_a(a),
    .i_b_sign(b_s), .i_b(b),
    .o_busy(busy1), .o_done(done1), .o_res(res1),
    .o_sign(sign1), .o_err(err1), .o_err_code(code1)
  );

  bcd_addsub_seq #(.DIGITS(D), .SIGN_DIGIT(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_op(op), .i_a_sign(a_s), .i_a(a),
    .i_b_sign(b_s), .i_b(b),
    .o_busy(busy0), .o_done(done0), .o_res(res0),
    .o_sign(sign0), .o_err(err0), .o_err_code(code0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic longint to_int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = D - 1; i >= 0; i--)
      r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint m);
    logic [W-1:0] v = '0;
    for (int i = 0; i < D; i++) begin
      v[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return v;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    for (int i = 0; i < D; i++)
      if (v[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // signed integer arithmetic, then range rules
  task automatic model(input bit sd, input bit o,
                       input bit as, input logic [W-1:0] av,
                       input bit bs, input logic [W-1:0] bv,
                       output logic [W-1:0] r, output bit s,
                       output bit e, output logic [1:0] c);
    longint va, vb, rr, mag, lim;
    lim = 1;
    for (int i = 0; i < D; i++) lim = lim * 10;
    va = as ? -to_int(av) : to_int(av);
    vb = bs ? -to_int(bv) : to_int(bv);
    rr = o ? va - vb : va + vb;
    mag = rr < 0 ? -rr : rr;
    r = '0; s = 1'b0; e = 1'b1; c = 2'b00;
    if (has_bad(av) || has_bad(bv)) c = 2'b10;
    else if (mag >= lim) c = 2'b01;
    else if (sd && rr < 0 && mag >= lim / 10) c = 2'b01;
    else begin
      r = to_bcd(mag);
      s = rr < 0;
      e = 1'b0;
    end
  endtask

  task automatic run_op(input bit o, input bit as,
                        input logic [W-1:0] av, input bit bs,
                        input logic [W-1:0] bv, input bit poke);
    logic [W-1:0] r1, r0;
    bit s1, s0, e1, e0;
    logic [1:0] c1, c0;
    int n, extra;
    model(1'b1, o, as, av, bs, bv, r1, s1, e1, c1);
    model(1'b0, o, as, av, bs, bv, r0, s0, e0, c0);
    @(negedge clk);
    op = o; a_s = as; a = av; b_s = bs; b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = ~o; a = '1; b = '1; a_s = ~as; b_s = ~bs;
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      @(posedge clk); #1;
      if (poke && k == 3) start = 1'b1;
      if (poke && k == 4) start = 1'b0;
      if (done1) n = k;
    end
    chk("latency", n, 8);
    chk("busy_at_done", busy1, 1'b1);
    chk("res", res1, r1);
    chk("sign", sign1, s1);
    chk("err", err1, e1);
    chk("code", code1, c1);
    chk("res_nosd", res0, r0);
    chk("sign_nosd", sign0, s0);
    chk("code_nosd", code0, c0);
    @(posedge clk); #1;
    chk("done_drop", done1, 1'b0);
    chk("busy_drop", busy1, 1'b0);
    chk("res_hold", res1, r1);
    if (poke) begin
      extra = 0;
      for (int k = 0; k < 12; k++) begin
        @(posedge clk); #1;
        if (done1) extra++;
      end
      chk("single_done", extra, 0);
    end
  endtask

  initial begin
    int extra;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; op = 1'b0;
    a_s = 1'b0; b_s = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_res", res1, '0);
    chk("rst_err", {err1, code1}, 3'b000);
    @(negedge clk); rst_n = 1'b1;

    run_op(0, 0, 24'h000123, 0, 24'h000456, 0);
    run_op(1, 0, 24'h000100, 0, 24'h000250, 0);
    run_op(1, 0, 24'h000000, 0, 24'h099999, 0);
    run_op(0, 0, 24'h999999, 0, 24'h000001, 0);
    run_op(1, 0, 24'h000000, 0, 24'h100000, 0);
    run_op(1, 1, 24'h000050, 1, 24'h000050, 0);
    run_op(0, 1, 24'h000020, 0, 24'h000070, 0);
    run_op(0, 0, 24'h00012A, 0, 24'h000000, 0);
    run_op(0, 0, 24'h0000A0, 0, 24'h999999, 0);
    run_op(1, 1, 24'h999999, 0, 24'h999999, 0);
    run_op(0, 1, 24'h012345, 1, 24'h054321, 1);

    // abandon an operation with reset mid-CALC
    @(negedge clk);
    op = 0; a = 24'h000123; b = 24'h000456; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("midrst_out", {busy1, done1, sign1, err1, code1}, 6'b0);
    chk("midrst_res", res1, '0);
    @(negedge clk); rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done1) extra++;
    end
    chk("midrst_nodone", extra, 0);
    run_op(1, 0, 24'h000777, 1, 24'h000223, 0);

    for (int t = 0; t < 30; t++) begin
      ra = '0; rb = '0;
      for (int i = 0; i < D; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 3) == 0) ra = ra & 24'h000FFF;
      if ($urandom_range(0, 3) == 0) rb = rb & 24'h00FFFF;
      if ($urandom_range(0, 9) == 0)
        ra[4 * $urandom_range(0, D - 1) +: 4] = 4'hB;
      run_op(1'($urandom), 1'($urandom), ra,
             1'($urandom), rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
